// File: rtl/mux_arbiter_rr.sv
// Round-robin arbiter and registered output stage for two 2-bit requesters.
// Burst limiting keeps one requester from starving the other; contador counts output transfers.
module mux_arbiter_rr #(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             valid_in0,
    input  logic [1:0]       data_in0,
    output logic             ready_out0,
    input  logic             valid_in1,
    input  logic [1:0]       data_in1,
    output logic             ready_out1,
    input  logic             ready_in,
    output logic             selector,
    output logic [1:0]       data_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] contador,
    output logic [1:0]       dbg_state
);

    // Handshake: a word moves on a rising edge when its valid and ready are both high
    // in the preceding cycle; valid and data hold until that happens.

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic             last_grant_q, last_grant_d;
    logic             selector_q, selector_d;
    logic [1:0]       data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic [CNT_W-1:0] contador_q, contador_d;

    logic             pick_vld;
    logic             pick_idx;
    logic             load_en;
    logic             accept;
    logic [BW-1:0]    burst_inc;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in0 && valid_in1) begin
                    pick_vld = 1'b1;
                    pick_idx = !last_grant_q;
                end else if (valid_in0) begin
                    pick_vld = 1'b1;
                    pick_idx = 1'b0;
                end else if (valid_in1) begin
                    pick_vld = 1'b1;
                    pick_idx = 1'b1;
                end
            end
            OWN0: begin
                if (valid_in0 && ((burst_q < BURST_LIM) || !valid_in1)) begin
                    pick_vld = 1'b1;
                    pick_idx = 1'b0;
                end else if (valid_in1) begin
                    pick_vld = 1'b1;
                    pick_idx = 1'b1;
                end
            end
            OWN1: begin
                if (valid_in1 && ((burst_q < BURST_LIM) || !valid_in0)) begin
                    pick_vld = 1'b1;
                    pick_idx = 1'b1;
                end else if (valid_in0) begin
                    pick_vld = 1'b1;
                    pick_idx = 1'b0;
                end
            end
            default: begin
                pick_vld = 1'b0;
                pick_idx = 1'b0;
            end
        endcase
    end

    assign load_en   = !valid_out_q || ready_in;
    assign accept    = pick_vld && load_en;
    assign burst_inc = (burst_q == BURST_LIM) ? burst_q : burst_q + BW'(1);

    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        last_grant_d = last_grant_q;
        selector_d   = selector_q;
        data_out_d   = data_out_q;
        valid_out_d  = valid_out_q;
        contador_d   = contador_q;

        if (accept) begin
            data_out_d   = pick_idx ? data_in1 : data_in0;
            valid_out_d  = 1'b1;
            selector_d   = pick_idx;
            last_grant_d = pick_idx;
            state_d      = pick_idx ? OWN1 : OWN0;
            // A continued grant only extends the burst if it follows an owned cycle.
            burst_d      = ((pick_idx == last_grant_q) && (state_q != IDLE)) ? burst_inc : BW'(1);
        end else if (load_en) begin
            valid_out_d = 1'b0;
            state_d     = IDLE;
            burst_d     = '0;
        end

        if (valid_out_q && ready_in) begin
            contador_d = contador_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            burst_q      <= '0;
            last_grant_q <= 1'b1;
            selector_q   <= 1'b0;
            data_out_q   <= 2'b00;
            valid_out_q  <= 1'b0;
            contador_q   <= '0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            last_grant_q <= last_grant_d;
            selector_q   <= selector_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            contador_q   <= contador_d;
        end
    end

    assign ready_out0 = reset_L && accept && !pick_idx;
    assign ready_out1 = reset_L && accept && pick_idx;
    assign selector   = selector_q;
    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign contador   = contador_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/mux_arbiter_rr.md
Name: mux_arbiter_rr

Overview:
Round-robin arbiter and output stage for the 2-bit two-input mux datapath. Two requesters present 2-bit data with valid/ready handshakes. The block chooses which requester owns the mux, registers the selected word, and presents it downstream with valid/ready backpressure. It enforces a burst limit so neither requester starves, and it counts completed output transfers.

Parameters:
BURST_MAX, 4, max consecutive grants to one requester while the other is requesting (≥1)
CNT_W, 6, width of the transfer counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset_L  input  1  synchronous reset, active low
valid_in0  input  1  requester 0 has data
data_in0  input  2  requester 0 data
ready_out0  output  1  requester 0 word accepted this cycle
valid_in1  input  1  requester 1 has data
data_in1  input  2  requester 1 data
ready_out1  output  1  requester 1 word accepted this cycle
ready_in  input  1  downstream can take data_out
selector  output  1  requester whose word is currently in data_out (last grant)
data_out  output  2  registered mux output
valid_out  output  1  data_out valid
contador  output  CNT_W  completed output transfers, wraps

Behaviour:
- One clock (clk). Reset is synchronous and active-low on reset_L, sampled on the rising edge.
- Reset values: valid_out=0, data_out=2'b00, selector=0, contador=0, state=IDLE, burst=0, last_grant=1 (first tie goes to requester 0).
- ready_out0/ready_out1 are forced to 0 while reset_L=0.
- load_en = !valid_out || ready_in.
- Output transfer occurs when valid_out && ready_in.
- Pick is combinational from the registered state:
  - IDLE: both valid → pick !last_grant; exactly one valid → pick that one; none valid → no pick.
  - OWNn: if valid_inn && (burst<BURST_MAX || !valid_in(other)) → pick n; else if valid_in(other) → pick other; else no pick.
- ready_outN = reset_L && load_en && (pick==N). At most one ready_out is high per cycle.
- Accept (pick exists and load_en=1), on the edge:
  - data_out ← data_inN; valid_out ← 1; selector ← N; last_grant ← N; state ← OWNN.
  - burst ← (N==last_grant && state!=IDLE) ? min(burst+1, BURST_MAX) : 1.
- No pick with load_en=1:
  - valid_out ← 0; state ← IDLE; burst ← 0.
  - data_out, selector and last_grant hold.
- load_en=0 (stall): all state and outputs hold. data_out and selector stay stable while valid_out && !ready_in.
- Latency: an accepted word appears on data_out with valid_out=1 on the next cycle. Throughput is 1 word/cycle when ready_in=1.
- Output transfer and new load in the same cycle are legal (load_en=1 via ready_in).
- contador increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
- burst register width is clog2(BURST_MAX+1); it saturates at BURST_MAX.
- Reset mid-operation: the word held in data_out is discarded and never counted. The next edge with reset_L=0 yields reset values. After release, arbitration restarts from IDLE with requester 0 preferred.
- Input data is sampled only on the accept edge; data_inN changes while ready_outN=0 are ignored.

Test Plan:
1. reset_L=0 for 2 cycles with valid_in0=valid_in1=1 → ready_out0=ready_out1=0, valid_out=0, data_out=00, selector=0, contador=0.
2. Only requester 0 valid, data 01,10,11 on consecutive cycles, ready_in=1 → data_out 01,10,11 one cycle later each, selector=0, valid_out=1 throughout, contador=3, no switch to requester 1.
3. Both valid continuously, data_in0=01, data_in1=10, ready_in=1, BURST_MAX=4 → grant sequence 0,0,0,0,1,1,1,1,0…; data_out 01×4, 10×4, 01…; selector follows.
4. valid_out=1 with data_out=10, ready_in=0 for 3 cycles, both requesters valid → data_out=10, selector stable, ready_out0=ready_out1=0, contador unchanged. On ready_in=1, transfer completes and a new word loads the same cycle.
5. 64 transfers with CNT_W=6 → contador counts 0..63, then reads 0 after the 64th transfer.
6. reset_L=0 for one cycle during the 2nd word of a requester-1 burst, both valid → next cycle valid_out=0, contador=0. After release, first grant goes to requester 0 and data_out=01.
